// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the access-size encodings, the controller state type, and the
// alignment/legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Returns 1 when the access cannot be performed: a half on an odd address,
    // a word that is not 4-byte aligned, or the reserved size encoding.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a 32-bit little-endian memory word and a request.
//   mem_word_i  word read from memory
//   addr_lo_i   byte offset within the word
//   size_i      access size (byte/half/word)
//   uns_i       1 = zero-extend loads, 0 = sign-extend
//   st_data_i   right-aligned store data
//   ld_data_o   extracted and extended load value
//   st_word_o   memory word with the addressed byte/half replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign shifted = mem_word_i >> {addr_lo_i, 3'b000};
    assign lane_b  = shifted[7:0];
    assign lane_h  = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    always_comb begin
        ld_data_o = mem_word_i;
        case (size_i)
            SZ_B:    ld_data_o = {{24{lane_b[7] & ~uns_i}}, lane_b};
            SZ_H:    ld_data_o = {{16{lane_h[15] & ~uns_i}}, lane_h};
            default: ld_data_o = mem_word_i;
        endcase
    end

    always_comb begin
        st_word_o = mem_word_i;
        case (size_i)
            SZ_B:    st_word_o[{addr_lo_i, 3'b000} +: 8] = st_data_i[7:0];
            SZ_H: begin
                if (addr_lo_i[1]) st_word_o[31:16] = st_data_i[15:0];
                else              st_word_o[15:0]  = st_data_i[15:0];
            end
            default: st_word_o = st_data_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a 32-bit word memory.
// Accepts byte/half/word loads and stores on a valid/ready handshake, issues
// word-aligned memory reads/writes (read-modify-write for sub-word stores)
// and returns extended load data or an error flag on a held response.
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake
//   req_write/size/unsigned/addr/wdata  request fields
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err                  load result, misalign/illegal flag
//   mem_addr/wdata/read/write/rdata     word memory interface
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | ready for a request
// ST_LOAD   | memory read, capture extended lane
// ST_RMW_RD | memory read, merge sub-word store data
// ST_WRITE  | one-cycle memory write of the buffered word
// ST_RESP   | response held until rsp_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    lsu_align u_align (
        .mem_word_i (mem_rdata),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .uns_i      (uns_q),
        .st_data_i  (wdata_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (access_bad(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SZ_W) begin
                        wbuf_d  = req_wdata;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = ld_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                wbuf_d  = st_word;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from the state register only, so reset removes them
    // asynchronously along with the state.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_read  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign mem_write = (state_q == ST_WRITE);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wbuf_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];
    int          wr_seen = 0;
    int          rd_seen = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    localparam logic [1:0]  EXT_SZ  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    localparam logic        EXT_UNS [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] EXT_ADR [7] = '{32'd27, 32'd27, 32'd26, 32'd24, 32'd24, 32'd25, 32'd24};
    localparam logic [31:0] EXT_EXP [7] = '{32'hffffff89, 32'h00000089, 32'hffff89ab,
                                            32'h0000cdef, 32'hffffffef, 32'h000000cd,
                                            32'h89abcdef};

    lsu_ctrl #(.ADDR_W(32), .SIZE_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_write) begin
            wr_seen++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (mem_read) rd_seen++;
    end

    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwr, output int nrd);
        int wr0;
        int rd0;
        @(negedge clk);
        wr0 = wr_seen;
        rd0 = rd_seen;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        nwr = wr_seen - wr0;
        nrd = rd_seen - rd0;
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrd;
        xact(1'b1, 2'b10, 1'b0, a, d, rd, er, lat, nwr, nrd);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=10000",
                     {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
        end
        total++;
        if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h want all 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrd;
        xact(1'b1, 2'b10, 1'b0, 32'd16, 32'h12345678, rd, er, lat, nwr, nrd);
        total++;
        if (lat !== 2 || nwr !== 1 || nrd !== 0) begin
            bad++;
            $display("FAIL wstore_timing lat=%0d wr=%0d rd=%0d want 2/1/0", lat, nwr, nrd);
        end
        total++;
        if (last_wr_addr !== 32'd16 || last_wr_data !== 32'h12345678) begin
            bad++;
            $display("FAIL wstore_mem addr=%h data=%h want 00000010/12345678",
                     last_wr_addr, last_wr_data);
        end
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL wstore_rsp err=%b rdata=%h want 0/0", er, rd);
        end
        xact(1'b0, 2'b10, 1'b0, 32'd16, 32'h0, rd, er, lat, nwr, nrd);
        total++;
        if (rd !== 32'h12345678 || er !== 1'b0 || lat !== 2 || nwr !== 0) begin
            bad++;
            $display("FAIL wload rdata=%h err=%b lat=%0d wr=%0d want 12345678/0/2/0",
                     rd, er, lat, nwr);
        end
    endtask

    task automatic test_subword_store;
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrd;
        store_word(32'd24, 32'h89abcdef);
        xact(1'b1, 2'b00, 1'b0, 32'd25, 32'hffffff55, rd, er, lat, nwr, nrd);
        total++;
        if (lat !== 3 || nwr !== 1 || nrd !== 1) begin
            bad++;
            $display("FAIL bstore_timing lat=%0d wr=%0d rd=%0d want 3/1/1", lat, nwr, nrd);
        end
        total++;
        if (last_wr_data !== 32'h89ab55ef || last_wr_addr !== 32'd24) begin
            bad++;
            $display("FAIL bstore_merge data=%h addr=%h want 89ab55ef/00000018",
                     last_wr_data, last_wr_addr);
        end
        xact(1'b0, 2'b10, 1'b0, 32'd24, 32'h0, rd, er, lat, nwr, nrd);
        total++;
        if (rd !== 32'h89ab55ef) begin
            bad++;
            $display("FAIL bstore_readback got=%h want 89ab55ef", rd);
        end
        store_word(32'd24, 32'h89abcdef);
        xact(1'b1, 2'b01, 1'b0, 32'd26, 32'h1234beef, rd, er, lat, nwr, nrd);
        total++;
        if (mem[6] !== 32'hbeefcdef || lat !== 3 || er !== 1'b0) begin
            bad++;
            $display("FAIL hstore_merge mem=%h lat=%0d err=%b want beefcdef/3/0",
                     mem[6], lat, er);
        end
    endtask

    task automatic test_load_ext;
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrd;
        store_word(32'd24, 32'h89abcdef);
        for (int i = 0; i < 7; i++) begin
            xact(1'b0, EXT_SZ[i], EXT_UNS[i], EXT_ADR[i], 32'h0, rd, er, lat, nwr, nrd);
            total++;
            if (rd !== EXT_EXP[i] || er !== 1'b0 || lat !== 2) begin
                bad++;
                $display("FAIL load_ext[%0d] rdata=%h err=%b lat=%0d want %h/0/2",
                         i, rd, er, lat, EXT_EXP[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat, nwr, nrd;
        logic        ew [3];
        logic [1:0]  es [3];
        logic [31:0] ea [3];
        ew = '{1'b1, 1'b0, 1'b0};
        es = '{2'b01, 2'b10, 2'b11};
        ea = '{32'd17, 32'd26, 32'd16};
        for (int i = 0; i < 3; i++) begin
            xact(ew[i], es[i], 1'b0, ea[i], 32'hdeadbeef, rd, er, lat, nwr, nrd);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nwr !== 0 || nrd !== 0) begin
                bad++;
                $display("FAIL err[%0d] err=%b rdata=%h lat=%0d wr=%0d rd=%0d want 1/0/1/0/0",
                         i, er, rd, lat, nwr, nrd);
            end
        end
        total++;
        if (mem[4] !== 32'h12345678) begin
            bad++;
            $display("FAIL err_mem_untouched got=%h want 12345678", mem[4]);
        end
    endtask

    task automatic test_hold;
        int n;
        mem[8] = 32'h0;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd24; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_write = 1'b1; req_size = 2'b10; req_addr = 32'd32;
            req_wdata = 32'hdeadbeef; req_valid = 1'b1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h89abcdef || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d] valid=%b rdata=%h ready=%b want 1/89abcdef/0",
                         c, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[8] !== 32'h0) begin
            bad++;
            $display("FAIL hold_release valid=%b ready=%b mem=%h want 0/1/00000000",
                     rsp_valid, req_ready, mem[8]);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_second_accept ready=%b want 0", req_ready);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++;
        if (mem[8] !== 32'hdeadbeef) begin
            bad++;
            $display("FAIL hold_second_store mem=%h want deadbeef", mem[8]);
        end
    endtask

    task automatic test_reset_abort;
        int wr0;
        int seen;
        store_word(32'd24, 32'h89abcdef);
        @(negedge clk);
        wr0 = wr_seen;
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd24; req_wdata = 32'h00000011; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        total++;
        if (mem_read !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_rmw read=%b ready=%b want 1/0", mem_read, req_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, mem_read, mem_write} !== 4'b1000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL abort_outputs ctrl=%b addr=%h wdata=%h want 1000/0/0",
                     {req_ready, rsp_valid, mem_read, mem_write}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen !== 0 || mem[6] !== 32'h89abcdef || wr_seen !== wr0) begin
            bad++;
            $display("FAIL abort_effects rsp_cycles=%0d mem=%h writes=%0d want 0/89abcdef/0",
                     seen, mem[6], wr_seen - wr0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        test_reset;
        test_word;
        test_subword_store;
        test_load_ext;
        test_errors;
        test_hold;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
